// File: rtl/tnn_result_framer.sv
// Frames TNN result beats into fixed-length images for the DMA read side.
// Optional trailer beat (img_count, WORDS_PER_IMG) under TNN_FRAMER_TRAILER_EN.
module tnn_result_framer #(
    parameter int WORDS_PER_IMG = 16
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [511:0] in_bits,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic         img_buffered,
    output logic [511:0] out_bits,
    output logic         out_vld,
    output logic         out_last,
    input  logic         out_rdy,
    output logic [31:0]  img_count,
    output logic         busy
);

`ifdef TNN_FRAMER_TRAILER_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        TRAILER = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
    } state_t;
`endif

    localparam logic [9:0] WPI = 10'(WORDS_PER_IMG);

    state_t       state_q, state_d;
    logic [9:0]   cnt_q, cnt_d;
    logic [511:0] out_bits_q, out_bits_d;
    logic         out_vld_q, out_vld_d;
    logic         out_last_q, out_last_d;
    logic [31:0]  img_count_q, img_count_d;
    logic         out_free;
    logic         accept;

    // Output register can take a new beat when empty or draining this cycle
    assign out_free = !out_vld_q || out_rdy;
    assign in_rdy   = (state_q == STREAM) && out_free;
    assign accept   = in_vld && in_rdy;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_bits_d  = out_bits_q;
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        img_count_d = img_count_q;
        if (out_vld_q && out_rdy) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            if (out_last_q) begin
                img_count_d = img_count_q + 32'd1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (img_buffered) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    out_bits_d = in_bits;
                    out_vld_d  = 1'b1;
                    out_last_d = 1'b0;
                    if (cnt_q + 10'd1 == WPI) begin
                        cnt_d = 10'd0;
`ifdef TNN_FRAMER_TRAILER_EN
                        state_d = TRAILER;
`else
                        out_last_d = 1'b1;
                        state_d    = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
`ifdef TNN_FRAMER_TRAILER_EN
            TRAILER: begin
                // Frame count reported before this frame's increment
                if (out_free) begin
                    out_bits_d         = '0;
                    out_bits_d[31:0]   = img_count_q;
                    out_bits_d[41:32]  = WPI;
                    out_vld_d          = 1'b1;
                    out_last_d         = 1'b1;
                    state_d            = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_bits_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            img_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_bits_q  <= out_bits_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            img_count_q <= img_count_d;
        end
    end

    assign out_bits  = out_bits_q;
    assign out_vld   = out_vld_q;
    assign out_last  = out_last_q;
    assign img_count = img_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tnn_result_framer.sv
// Scoreboard bench for tnn_result_framer with WORDS_PER_IMG=4.
// Trailer expectations follow TNN_FRAMER_TRAILER_EN.
module tb_tnn_result_framer;

    localparam int W = 4;
`ifdef TNN_FRAMER_TRAILER_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         areset;
    logic [511:0] in_bits;
    logic         in_vld;
    logic         in_rdy;
    logic         img_buffered;
    logic [511:0] out_bits;
    logic         out_vld;
    logic         out_last;
    logic         out_rdy;
    logic [31:0]  img_count;
    logic         busy;

    tnn_result_framer #(.WORDS_PER_IMG(W)) dut (
        .aclk(aclk), .areset(areset),
        .in_bits(in_bits), .in_vld(in_vld), .in_rdy(in_rdy),
        .img_buffered(img_buffered),
        .out_bits(out_bits), .out_vld(out_vld), .out_last(out_last),
        .out_rdy(out_rdy), .img_count(img_count), .busy(busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [511:0] bits;
        logic         last;
        int           cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          popped = 0;
    int          bidx = 0;
    logic [31:0] mdl = 32'd0;
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;

    always @(posedge aclk) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: latency on new beats, content on each output handshake
    always @(negedge aclk) begin
        if (areset) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (out_vld && (!prev_v || prev_hs) && sb.size() > 0
                && sb[0].cyc >= 0) begin
                chk("latency", 64'(cyc), 64'(sb[0].cyc));
            end
            if (out_vld && out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             out_bits[63:0]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    popped++;
                    if (out_bits !== e.bits || out_last !== e.last) begin
                        fails++;
                        $display("FAIL beat: got %0h last %0b expected %0h last %0b",
                                 out_bits[63:0], out_last, e.bits[63:0], e.last);
                    end
                end
            end
            prev_v  = out_vld;
            prev_hs = out_vld && out_rdy;
        end
    end

    task automatic push_beat(logic [511:0] b);
        exp_t e;
        e.bits = b;
        e.last = (bidx == W - 1) && !TR;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        if (bidx == W - 1) begin
            if (TR) begin
                exp_t t;
                t.bits        = '0;
                t.bits[31:0]  = mdl;
                t.bits[41:32] = 10'(W);
                t.last        = 1'b1;
                t.cyc         = -1;
                sb.push_back(t);
            end
            mdl  = mdl + 32'd1;
            bidx = 0;
        end else begin
            bidx++;
        end
    endtask

    task automatic send(logic [511:0] base, int n);
        for (int i = 0; i < n; i++) begin
            bit ok;
            @(posedge aclk);
            #1;
            in_bits = base + 512'(i);
            in_vld  = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge aclk);
                if (in_rdy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk("send_timeout", 64'(0), 64'(1));
                break;
            end
            push_beat(in_bits);
        end
        @(posedge aclk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(negedge aclk);
            k++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'(0));
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_img_count", 64'(img_count), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_bits", out_bits[63:0], 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        sb.delete();
        bidx = 0;
        mdl  = 32'd0;
        img_buffered = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        areset       = 1'b1;
        in_bits      = '0;
        in_vld       = 1'b0;
        img_buffered = 1'b0;
        out_rdy      = 1'b1;
        do_reset();

        // Not buffered: no input accepted, nothing emitted
        @(posedge aclk);
        #1;
        in_vld  = 1'b1;
        in_bits = 512'hDEAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("idle_in_rdy", 64'(in_rdy), 64'(0));
            chk("idle_out_vld", 64'(out_vld), 64'(0));
        end
        in_vld = 1'b0;

        // Basic frame
        img_buffered = 1'b1;
        p0 = popped;
        send(512'hA0, W);
        drain();
        chk("frame1_beats", 64'(popped - p0), 64'(W + (TR ? 1 : 0)));
        chk("frame1_img_count", 64'(img_count), 64'(mdl));
        chk("frame1_img_is_1", 64'(img_count), 64'(1));

        // Backpressure mid-frame
        p0 = popped;
        fork
            send(512'hB0, W);
            begin
                int k;
                k = 0;
                while (popped - p0 < 2 && k < 200) begin
                    @(negedge aclk);
                    k++;
                end
                @(posedge aclk);
                #1;
                out_rdy = 1'b0;
                repeat (5) begin
                    @(negedge aclk);
                    chk("stall_out_vld", 64'(out_vld), 64'(1));
                    chk("stall_in_rdy", 64'(in_rdy), 64'(0));
                    if (sb.size() > 0)
                        chk("stall_bits", out_bits[63:0], sb[0].bits[63:0]);
                end
                @(posedge aclk);
                #1;
                out_rdy = 1'b1;
            end
        join
        drain();
        chk("stall_beats", 64'(popped - p0), 64'(W + (TR ? 1 : 0)));
        chk("stall_img_count", 64'(img_count), 64'(mdl));

        // Reset mid-frame, then a clean frame
        send(512'hC0, 2);
        do_reset();
        img_buffered = 1'b1;
        p0 = popped;
        send(512'hD0, W);
        drain();
        chk("post_rst_beats", 64'(popped - p0), 64'(W + (TR ? 1 : 0)));
        chk("post_rst_img_count", 64'(img_count), 64'(1));

        // img_buffered dropped mid-frame is ignored
        p0 = popped;
        fork
            send(512'hE0, W);
            begin
                @(negedge aclk);
                @(negedge aclk);
                img_buffered = 1'b0;
            end
        join
        drain();
        chk("drop_buf_beats", 64'(popped - p0), 64'(W + (TR ? 1 : 0)));

        // img_count wrap
        @(posedge aclk);
        #1;
        force dut.img_count_q = 32'hFFFF_FFFF;
        @(posedge aclk);
        #1;
        release dut.img_count_q;
        mdl = 32'hFFFF_FFFF;
        chk("preload", 64'(img_count), 64'hFFFF_FFFF);
        img_buffered = 1'b1;
        send(512'hF0, W);
        drain();
        chk("wrap_img_count", 64'(img_count), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
